// File: rtl/ntt_ctrl.sv
// Address/handshake sequencer for an in-place Gentleman-Sande (DIF) NTT built around one
// pipelined butterfly: issues N/2 butterflies per stage, drains the pipe, then advances.
module ntt_ctrl #(
  parameter int LOG_N  = 8,
  parameter int BF_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [LOG_N-1:0] stage,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr0,
  output logic [LOG_N-1:0] rd_addr1,
  output logic [LOG_N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr0,
  output logic [LOG_N-1:0] wr_addr1
);

  localparam int KW = LOG_N - 1;
  localparam int CW = $clog2(BF_LAT + 1);
  localparam logic [LOG_N-1:0] LAST_STAGE = LOG_N'(LOG_N - 1);
  localparam logic [KW-1:0]    LAST_K     = '1;
  localparam logic [CW-1:0]    LAST_CNT   = CW'(BF_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           nxt_state;
  logic [KW-1:0]    k;
  logic [KW-1:0]    nxt_k;
  logic [LOG_N-1:0] nxt_stage;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    nxt_cnt;

  // Butterfly span for stage s: 2^(LOG_N-1-s).
  function automatic logic [LOG_N-1:0] half_of(input logic [LOG_N-1:0] s);
    return LOG_N'(1) << (LAST_STAGE - s);
  endfunction

  // x0 address: group index g placed above a (LOG_N-s)-bit offset, plus j within the group.
  function automatic logic [LOG_N-1:0] addr0_of(input logic [LOG_N-1:0] s,
                                               input logic [KW-1:0]    kk);
    logic [LOG_N-1:0] sh;
    logic [LOG_N-1:0] kx;
    sh = LAST_STAGE - s;
    kx = {1'b0, kk};
    return ((kx >> sh) << (sh + LOG_N'(1))) | (kx & (half_of(s) - LOG_N'(1)));
  endfunction

  // Twiddle index j << s; j < 2^(LOG_N-1-s), so the shift never leaves LOG_N-1 bits.
  function automatic logic [KW-1:0] tw_of(input logic [LOG_N-1:0] s,
                                         input logic [KW-1:0]    kk);
    logic [KW-1:0] mask;
    mask = KW'(half_of(s) - LOG_N'(1));
    return (kk & mask) << s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    nxt_k     = k;
    nxt_stage = stage;
    nxt_cnt   = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          nxt_state = S_ISSUE;
          nxt_k     = '0;
          nxt_stage = '0;
        end
      end
      S_ISSUE: begin
        nxt_k   = k + KW'(1);
        nxt_cnt = '0;
        if (k == LAST_K) nxt_state = S_DRAIN;
      end
      S_DRAIN: begin
        nxt_cnt = cnt + CW'(1);
        if (cnt == LAST_CNT) begin
          if (stage == LAST_STAGE) begin
            nxt_state = S_DONE;
          end else begin
            nxt_state = S_ISSUE;
            nxt_stage = stage + LOG_N'(1);
            nxt_k     = '0;
          end
        end
      end
      S_DONE:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == S_ISSUE) || (state == S_DRAIN);
    done  = (state == S_DONE);
    rd_en = (state == S_ISSUE);
  end

  // Issue stage: addresses are computed from the next (stage, k) so they are registered
  // and valid in the same cycle rd_en is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k        <= '0;
      stage    <= '0;
      cnt      <= '0;
      rd_addr0 <= '0;
      rd_addr1 <= '0;
      tw_addr  <= '0;
    end else begin
      k     <= nxt_k;
      stage <= nxt_stage;
      cnt   <= nxt_cnt;
      if (nxt_state == S_ISSUE) begin
        rd_addr0 <= addr0_of(nxt_stage, nxt_k);
        rd_addr1 <= addr0_of(nxt_stage, nxt_k) + half_of(nxt_stage);
        tw_addr  <= tw_of(nxt_stage, nxt_k);
      end
    end
  end

  logic [BF_LAT-1:0] vld_p;
  logic [LOG_N-1:0]  a0_p [BF_LAT];
  logic [LOG_N-1:0]  a1_p [BF_LAT];

  // Write-back delay line: addresses only move with a valid entry, so the tail holds the
  // last written pair while wr_en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
      for (int i = 0; i < BF_LAT; i++) begin
        a0_p[i] <= '0;
        a1_p[i] <= '0;
      end
    end else begin
      vld_p[0] <= rd_en;
      if (rd_en) begin
        a0_p[0] <= rd_addr0;
        a1_p[0] <= rd_addr1;
      end
      for (int i = 1; i < BF_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        if (vld_p[i-1]) begin
          a0_p[i] <= a0_p[i-1];
          a1_p[i] <= a1_p[i-1];
        end
      end
    end
  end

  assign wr_en    = vld_p[BF_LAT-1];
  assign wr_addr0 = a0_p[BF_LAT-1];
  assign wr_addr1 = a1_p[BF_LAT-1];

endmodule

// File: tb/tb_ntt_ctrl.sv
// Scoreboard bench for ntt_ctrl: a small (LOG_N=3, BF_LAT=2) instance for exact traces
// and a large (LOG_N=8, BF_LAT=5) instance for write coverage and completion time.
module tb_ntt_ctrl;

  typedef struct packed {
    int cyc;
    int a0;
    int a1;
    int tw;
    int st;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       busy_a, done_a, rd_en_a, wr_en_a;
  logic [2:0] stage_a, rd0_a, rd1_a, wr0_a, wr1_a;
  logic [1:0] tw_a;
  logic       busy_b, done_b, rd_en_b, wr_en_b;
  logic [7:0] stage_b, rd0_b, rd1_b, wr0_b, wr1_b;
  logic [6:0] tw_b;

  ntt_ctrl #(.LOG_N(3), .BF_LAT(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .stage(stage_a), .rd_en(rd_en_a), .rd_addr0(rd0_a), .rd_addr1(rd1_a),
    .tw_addr(tw_a), .wr_en(wr_en_a), .wr_addr0(wr0_a), .wr_addr1(wr1_a)
  );

  ntt_ctrl #(.LOG_N(8), .BF_LAT(5)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .stage(stage_b), .rd_en(rd_en_b), .rd_addr0(rd0_b), .rd_addr1(rd1_b),
    .tw_addr(tw_b), .wr_en(wr_en_b), .wr_addr0(wr0_b), .wr_addr1(wr1_b)
  );

  ev_t obs_rd[$], obs_wr[$], exp_rd[$], exp_wr[$], obs_wr_b[$];
  int  obs_done[$], obs_busy[$], obs_done_b[$];
  int  checks = 0;
  int  errors = 0;

  function automatic ev_t mk_ev(input int c, input int a0, input int a1, input int tw,
                                input int st);
    ev_t e;
    e.cyc = c; e.a0 = a0; e.a1 = a1; e.tw = tw; e.st = st;
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rd_en_a) obs_rd.push_back(mk_ev(cyc, int'(rd0_a), int'(rd1_a), int'(tw_a), int'(stage_a)));
    if (wr_en_a) obs_wr.push_back(mk_ev(cyc, int'(wr0_a), int'(wr1_a), 0, 0));
    if (done_a)  obs_done.push_back(cyc);
    if (busy_a)  obs_busy.push_back(cyc);
    if (wr_en_b) obs_wr_b.push_back(mk_ev(cyc, int'(wr0_b), int'(wr1_b), 0, 0));
    if (done_b)  obs_done_b.push_back(cyc);
  end

  task automatic clear_obs();
    obs_rd.delete(); obs_wr.delete(); obs_done.delete(); obs_busy.delete();
  endtask

  // Reference trace for the small instance: groups outer, offsets inner, natural order.
  task automatic fill_exp(input int base);
    exp_rd.delete(); exp_wr.delete();
    for (int s = 0; s < 3; s++) begin
      int half, n;
      half = 4 >> s;
      n = 0;
      for (int g = 0; g < (1 << s); g++) begin
        for (int j = 0; j < half; j++) begin
          int a0;
          a0 = g * 2 * half + j;
          exp_rd.push_back(mk_ev(base + s * 6 + n, a0, a0 + half, (j * (1 << s)) % 4, s));
          exp_wr.push_back(mk_ev(base + s * 6 + n + 2, a0, a0 + half, 0, 0));
          n++;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_a, done_a, rd_en_a, wr_en_a} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl_a: got %b want 0000", {busy_a, done_a, rd_en_a, wr_en_a});
    end
    checks++;
    if ({stage_a, rd0_a, rd1_a, tw_a, wr0_a, wr1_a} !== 17'd0) begin
      errors++; $display("FAIL reset_addr_a: got %h want 0", {stage_a, rd0_a, rd1_a, tw_a, wr0_a, wr1_a});
    end
    checks++;
    if ({busy_b, done_b, rd_en_b, wr_en_b, stage_b, rd0_b, rd1_b, tw_b, wr0_b, wr1_b} !== 51'd0) begin
      errors++; $display("FAIL reset_b: got %h want 0", {busy_b, done_b, rd_en_b, wr_en_b, stage_b, rd0_b, rd1_b, tw_b, wr0_b, wr1_b});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_a, rd_en_a, wr_en_a} !== 3'b000) begin
      errors++; $display("FAIL idle_after_reset: got %b want 000", {busy_a, rd_en_a, wr_en_a});
    end
  endtask

  task automatic test_stages();
    int base;
    clear_obs();
    @(negedge clk);
    base = cyc + 1;
    fill_exp(base);
    start_a = 1'b1;
    for (int r = 1; r <= 24; r++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    checks++;
    if (obs_rd.size() != 12 || obs_wr.size() != 12) begin
      errors++; $display("FAIL stages_count: got rd=%0d wr=%0d want 12/12", obs_rd.size(), obs_wr.size());
    end
    for (int i = 0; i < 12; i++) begin
      ev_t g;
      g = (i < obs_rd.size()) ? obs_rd[i] : mk_ev(-1, -1, -1, -1, -1);
      checks++;
      if (g !== exp_rd[i]) begin
        errors++; $display("FAIL stages_rd[%0d]: got cyc=%0d a=(%0d,%0d) tw=%0d st=%0d want cyc=%0d a=(%0d,%0d) tw=%0d st=%0d",
          i, g.cyc - base + 1, g.a0, g.a1, g.tw, g.st, exp_rd[i].cyc - base + 1, exp_rd[i].a0, exp_rd[i].a1, exp_rd[i].tw, exp_rd[i].st);
      end
      g = (i < obs_wr.size()) ? obs_wr[i] : mk_ev(-1, -1, -1, -1, -1);
      checks++;
      if (g !== exp_wr[i]) begin
        errors++; $display("FAIL stages_wr[%0d]: got cyc=%0d a=(%0d,%0d) want cyc=%0d a=(%0d,%0d)",
          i, g.cyc - base + 1, g.a0, g.a1, exp_wr[i].cyc - base + 1, exp_wr[i].a0, exp_wr[i].a1);
      end
    end
    checks++;
    if (obs_done.size() != 1 || obs_done[0] != base + 18) begin
      errors++; $display("FAIL done_cycle: got n=%0d first=%0d want n=1 cycle 19", obs_done.size(),
        (obs_done.size() > 0) ? obs_done[0] - base + 1 : -1);
    end
    checks++;
    if (obs_busy.size() != 18 || obs_busy[0] != base || obs_busy[obs_busy.size()-1] != base + 17) begin
      errors++; $display("FAIL busy_window: got n=%0d want 18 cycles from 1 to 18", obs_busy.size());
    end
  endtask

  task automatic test_start_ignored();
    int base;
    clear_obs();
    @(negedge clk);
    base = cyc + 1;
    fill_exp(base);
    start_a = 1'b1;
    for (int r = 1; r <= 24; r++) begin
      @(negedge clk);
      start_a = (r == 5 || r == 10);
    end
    start_a = 1'b0;
    checks++;
    if (obs_rd.size() != 12 || obs_wr.size() != 12 || obs_done.size() != 1) begin
      errors++; $display("FAIL ignored_count: got rd=%0d wr=%0d done=%0d want 12/12/1", obs_rd.size(), obs_wr.size(), obs_done.size());
    end
    for (int i = 0; i < 12; i++) begin
      ev_t g, w;
      g = (i < obs_rd.size()) ? obs_rd[i] : mk_ev(-1, -1, -1, -1, -1);
      w = (i < obs_wr.size()) ? obs_wr[i] : mk_ev(-1, -1, -1, -1, -1);
      checks++;
      if (g !== exp_rd[i] || w !== exp_wr[i]) begin
        errors++; $display("FAIL ignored_trace[%0d]: got rd cyc=%0d a0=%0d wr cyc=%0d a0=%0d want rd cyc=%0d a0=%0d wr cyc=%0d a0=%0d",
          i, g.cyc - base + 1, g.a0, w.cyc - base + 1, w.a0, exp_rd[i].cyc - base + 1, exp_rd[i].a0, exp_wr[i].cyc - base + 1, exp_wr[i].a0);
      end
    end
    checks++;
    if (obs_done.size() > 0 && obs_done[0] != base + 18) begin
      errors++; $display("FAIL ignored_done: got cycle %0d want 19", obs_done[0] - base + 1);
    end
  endtask

  task automatic test_start_held();
    int base;
    clear_obs();
    @(negedge clk);
    base = cyc + 1;
    start_a = 1'b1;
    for (int r = 1; r <= 44; r++) begin
      @(negedge clk);
      start_a = (r <= 21);
    end
    start_a = 1'b0;
    checks++;
    if (obs_done.size() != 2 || obs_done[0] != base + 18 || obs_done[1] != base + 38) begin
      errors++; $display("FAIL held_done: got n=%0d want done at 19 and 39", obs_done.size());
    end
    checks++;
    if (obs_rd.size() != 24 || obs_rd[12].cyc != base + 20) begin
      errors++; $display("FAIL held_restart: got rd=%0d second_first=%0d want 24 reads, restart cycle 21",
        obs_rd.size(), (obs_rd.size() > 12) ? obs_rd[12].cyc - base + 1 : -1);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    clear_obs();
    @(negedge clk);
    start_a = 1'b1;
    for (int r = 1; r <= 7; r++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy_a, done_a, rd_en_a, wr_en_a, stage_a, rd0_a, rd1_a, tw_a, wr0_a, wr1_a} !== 21'd0) begin
      errors++; $display("FAIL async_reset: got %h want 0", {busy_a, done_a, rd_en_a, wr_en_a, stage_a, rd0_a, rd1_a, tw_a, wr0_a, wr1_a});
    end
    clear_obs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (obs_wr.size() != 0 || obs_rd.size() != 0 || obs_done.size() != 0) begin
      errors++; $display("FAIL reset_drop: got wr=%0d rd=%0d done=%0d want 0/0/0", obs_wr.size(), obs_rd.size(), obs_done.size());
    end
    base = cyc + 1;
    fill_exp(base);
    start_a = 1'b1;
    for (int r = 1; r <= 24; r++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    checks++;
    if (obs_rd.size() != 12 || obs_wr.size() != 12) begin
      errors++; $display("FAIL restart_count: got rd=%0d wr=%0d want 12/12", obs_rd.size(), obs_wr.size());
    end
    for (int i = 0; i < 4; i++) begin
      ev_t g, w;
      g = (i < obs_rd.size()) ? obs_rd[i] : mk_ev(-1, -1, -1, -1, -1);
      w = (i < obs_wr.size()) ? obs_wr[i] : mk_ev(-1, -1, -1, -1, -1);
      checks++;
      if (g !== exp_rd[i] || w !== exp_wr[i]) begin
        errors++; $display("FAIL restart_stage0[%0d]: got rd cyc=%0d a=(%0d,%0d) tw=%0d wr cyc=%0d want rd cyc=%0d a=(%0d,%0d) tw=%0d wr cyc=%0d",
          i, g.cyc - base + 1, g.a0, g.a1, g.tw, w.cyc - base + 1, exp_rd[i].cyc - base + 1, exp_rd[i].a0, exp_rd[i].a1, exp_rd[i].tw, exp_wr[i].cyc - base + 1);
      end
    end
  endtask

  task automatic test_large();
    int base, bad, rel, s, missing;
    int cnt_b [8][256];
    foreach (cnt_b[i, j]) cnt_b[i][j] = 0;
    obs_wr_b.delete(); obs_done_b.delete();
    @(negedge clk);
    base = cyc + 1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int n = 0; n < 1200 && obs_done_b.size() == 0; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (obs_done_b.size() != 1 || obs_done_b[0] != base + 1064) begin
      errors++; $display("FAIL large_done: got n=%0d cycle=%0d want n=1 cycle 1065", obs_done_b.size(),
        (obs_done_b.size() > 0) ? obs_done_b[0] - base + 1 : -1);
    end
    checks++;
    if (obs_wr_b.size() != 1024) begin
      errors++; $display("FAIL large_wr_count: got %0d want 1024", obs_wr_b.size());
    end
    bad = 0;
    foreach (obs_wr_b[i]) begin
      rel = obs_wr_b[i].cyc - base + 1;
      s = (rel - 6) / 133;
      if (rel < 6 || s > 7 || (rel - 6) % 133 >= 128 || obs_wr_b[i].a1 - obs_wr_b[i].a0 != (128 >> s)) begin
        bad++;
      end else begin
        cnt_b[s][obs_wr_b[i].a0]++;
        cnt_b[s][obs_wr_b[i].a1]++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL large_wr_timing: got %0d misplaced writes want 0", bad);
    end
    for (int st = 0; st < 8; st++) begin
      missing = 0;
      for (int a = 0; a < 256; a++) if (cnt_b[st][a] != 1) missing++;
      checks++;
      if (missing != 0) begin
        errors++; $display("FAIL large_stage%0d_coverage: got %0d addresses not written once want 0", st, missing);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stages();
    test_start_ignored();
    test_start_held();
    test_reset_mid();
    test_large();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
